// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Op codes match the execute-stage op field; magnitude() strips signs before iterating.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;
    localparam logic [31:0] ZERO       = 32'h0000_0000;

    // 0x80000000 maps to itself, which reads correctly as 2^31 unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds {hi, lo}: {partial product, multiplier} or {remainder, dividend/quotient}.
module mdu_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [33:0] diff;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        rem_shift = {acc[63:32], acc[31]};
        diff      = {1'b0, rem_shift} - {2'b00, operand};
        acc_next  = {mul_sum, acc[31:1]};
        if (is_div) begin
            if (diff[33]) begin
                acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
            end else begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/CALC/DONE FSM, 32 radix-2 steps,
// sign fix-up on the final step and a one-cycle HI/LO write pulse.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hiData,
    output logic        whi,
    output logic [31:0] loData,
    output logic        wlo
);

    localparam logic [5:0] ITER_LAST = 6'(ITER_COUNT - 1);

    state_t      state;
    logic [5:0]  count;
    op_t         op_q;
    logic [31:0] operand;
    logic [63:0] acc;
    logic        neg_q;
    logic        neg_r;

    op_t         op_in;
    logic        in_signed;
    logic        in_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        is_div_q;
    logic [63:0] step_out;
    logic [63:0] product;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign op_in     = op_t'(op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign mag_a     = magnitude(opA, in_signed);
    assign mag_b     = magnitude(opB, in_signed);
    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mdu_step u_step (
        .is_div   (is_div_q),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_out)
    );

    // Sign fix-up applied to the last step's output so results land in DONE.
    always_comb begin
        product = neg_q ? -step_out : step_out;
        res_hi  = product[63:32];
        res_lo  = product[31:0];
        if (is_div_q) begin
            res_lo = neg_q ? -step_out[31:0]  : step_out[31:0];
            res_hi = neg_r ? -step_out[63:32] : step_out[63:32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            hiData  <= ZERO;
            loData  <= ZERO;
            op_q    <= OP_MULT;
            operand <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        neg_q <= in_signed & (opA[31] ^ opB[31]);
                        neg_r <= in_signed & opA[31];
                        count <= '0;
                        busy  <= 1'b1;
                        if (in_div && (opB == ZERO)) begin
                            hiData <= opA;
                            loData <= DIV0_LO;
                            state  <= ST_DONE;
                        end else begin
                            operand <= in_div ? mag_b : mag_a;
                            acc     <= {ZERO, (in_div ? mag_a : mag_b)};
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc   <= step_out;
                    count <= count + 6'd1;
                    if (count == ITER_LAST) begin
                        hiData <= res_hi;
                        loData <= res_lo;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving during DONE must still kill the write in that same cycle.
    assign whi = (state == ST_DONE) && !cancel;
    assign wlo = (state == ST_DONE) && !cancel;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high (`RstEnable).
REQ-003 start  input  1  one-cycle operation request from execute stage; sampled only in IDLE.
REQ-004 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 opA  input  32  rs operand (multiplicand / dividend); sampled with start.
REQ-006 opB  input  32  rt operand (multiplier / divisor); sampled with start.
REQ-007 cancel  input  1  pipeline flush; aborts any in-flight operation.
REQ-008 busy  output  1  registered stall request to pipeline control.
REQ-009 hiData  output  32  value for HI register write port.
REQ-010 whi  output  1  HI write enable (`Valid), one-cycle pulse.
REQ-011 loData  output  32  value for LO register write port.
REQ-012 wlo  output  1  LO write enable (`Valid), one-cycle pulse.

Function
REQ-013 FSM states IDLE, CALC, DONE; 6-bit iteration counter.
REQ-014 IDLE: start=1 latches op/opA/opB, counter=0; next state CALC (DONE directly if DIV/DIVU with opB=0).
REQ-015 CALC: one radix-2 step per cycle, exactly 32 cycles, then DONE.
REQ-016 Latency: start at cycle T -> whi=wlo=1 at T+33, IDLE at T+34; divide-by-zero -> whi=wlo=1 at T+1.
REQ-017 busy=1 in CALC and DONE, 0 in IDLE; start while busy is ignored.
REQ-018 DONE: whi=wlo=1 for exactly one cycle, hiData/loData valid that cycle; next state IDLE.
REQ-019 whi=wlo=0 in every other cycle; hiData/loData hold last result outside DONE.
REQ-020 Multiply: unsigned shift-add on 32-bit magnitudes, 64-bit product; hi=product[63:32], lo=product[31:0].
REQ-021 MULT: product two's-complement negated when operand signs differ.
REQ-022 Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
REQ-023 DIV: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-024 Magnitude of 0x80000000 is 2^31 unsigned; 0x80000000 DIV 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
REQ-025 Divisor zero (DIV or DIVU): hi=opA, lo=0xFFFFFFFF, no iteration.
REQ-026 cancel=1 in any state: next state IDLE, busy=0 next cycle, no whi/wlo pulse; cancel in DONE suppresses that cycle's pulse.
REQ-027 cancel and start in the same IDLE cycle: cancel wins, operation not accepted.

Reset
REQ-028 rst=1: state IDLE, counter 0, busy=0, whi=wlo=0, hiData=loData=`Zero, internal operand/accumulator registers cleared.
REQ-029 rst mid-operation abandons it; no write pulse after reset deasserts.
REQ-030 rst has priority over cancel and start.

Structure
REQ-031 Op encodings, state encodings, ITER_COUNT=32 and the divide-by-zero LO constant belong in shared define.v alongside `RstEnable/`Valid/`Zero.
REQ-032 One sub-module: mdu_step, a combinational single radix-2 iteration (add-shift for multiply, trial-subtract-shift for divide); FSM, counter, sign fix-up and output registers stay in mult_div_unit.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at T+33 whi=wlo=1, hi=0xFFFFFFFE, lo=0x00000001; busy high T+1..T+33.
REQ-034 MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 0x12345678 / 0 -> at T+1 hi=0x12345678, lo=0xFFFFFFFF, busy low at T+2.
REQ-037 DIVU 100/7 with cancel at T+10 -> busy=0 at T+11, no whi/wlo; new start at T+11 DIVU 100/7 -> lo=14, hi=2 at T+44.
REQ-038 rst at T+5 of a MULT, start ignored while busy -> outputs zero, no write pulse, next start accepted normally.
